// File: rtl/st40_link_pkg.sv
// Shared definitions for the self-trigger link receive path.
// Link control codes (always sent with KFLAG_CTRL on kin), header length and
// the receiver FSM state type.
package st40_link_pkg;

  localparam logic [31:0] K_IDLE     = 32'h0000_00BC;
  localparam logic [31:0] K_SOF      = 32'h0000_003C;
  localparam logic [31:0] K_EOF      = 32'h0000_00DC;
  localparam logic [3:0]  KFLAG_CTRL = 4'b0001;
  localparam int unsigned N_HDR      = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_TRL,
    S_EOF
  } rx_state_t;

  // True when the word is the given control code with the control K-flag pattern.
  function automatic logic is_code(input logic [31:0] d, input logic [3:0] k,
                                   input logic [31:0] code);
    return (k == KFLAG_CTRL) && (d == code);
  endfunction

endpackage

// File: rtl/st40_frame_receiver_if.sv
// Link-side bundle of the frame receiver.
//   din/kin             : incoming 32-bit word and its per-byte K-flags
//   m_data/m_valid/m_last : outgoing payload stream (no backpressure)
// master = link/stream source side (test driver), slave = receiver.
interface st40_frame_receiver_if;
  logic [31:0] din;
  logic [3:0]  kin;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;

  modport master (output din, kin, input  m_data, m_valid, m_last);
  modport slave  (input  din, kin, output m_data, m_valid, m_last);
endinterface

// File: rtl/st40_rx_counter.sv
// Frame event counter.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one event this cycle
//   clr      : synchronous clear, dominates a same-cycle inc
//   count    : current value; wraps at 2^CNT_W when WRAP=1, else saturates
module st40_rx_counter #(
  parameter int unsigned CNT_W = 32,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (WRAP || !(&count))) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/st40_frame_receiver.sv
// Receive end of the self-trigger output link.
// Deframes SOF/H0/H1/H2/payload/TRAILER/EOF records, unpacks the header,
// streams the payload and checks the XOR trailer and the closing EOF.
//   fclk, reset_fclk : clock, synchronous active-high reset
//   link (slave)     : din/kin in, m_data/m_valid/m_last payload stream out
//   clear_counters   : synchronous clear of ok_count/err_count
//   hdr_*            : fields of the last accepted header, hdr_valid pulse
//   frame_done/good  : end-of-frame-attempt pulse and its verdict
//   err_*            : per-cause error pulses
//   ok_count/err_count : good/bad frame counters
// All outputs are registered, one cycle behind the word that caused them.
module st40_frame_receiver
  import st40_link_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = 32,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                 fclk,
  input  logic                 reset_fclk,
  st40_frame_receiver_if.slave link,
  input  logic                 clear_counters,
  output logic [5:0]           hdr_version,
  output logic [5:0]           hdr_detector,
  output logic [9:0]           hdr_crate,
  output logic [3:0]           hdr_slot,
  output logic [5:0]           hdr_channel,
  output logic [63:0]          hdr_timestamp,
  output logic                 hdr_valid,
  output logic                 frame_done,
  output logic                 frame_good,
  output logic                 err_kchar,
  output logic                 err_checksum,
  output logic                 err_eof,
  output logic [CNT_W-1:0]     ok_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam int unsigned WC_MAX = (PAYLOAD_WORDS > N_HDR) ? PAYLOAD_WORDS : N_HDR;
  localparam int unsigned WC_W   = $clog2(WC_MAX) + 1;

  rx_state_t         state_q, state_d;
  logic [WC_W-1:0]   wcnt_q;
  logic [31:0]       csum_q;
  logic              csum_bad_q;
  logic [31:0]       h0_q, h1_q;
  logic [31:0]       m_data_q;
  logic              m_valid_q, m_last_q;

  logic is_sof, is_eof, k_any, kerr, hdr_last, pay_last;
  logic m_valid_d, m_last_d, hdr_load, done_d, good_d;
  logic err_k_d, err_c_d, err_e_d, csum_clr, csum_acc;

  assign is_sof   = is_code(link.din, link.kin, K_SOF);
  assign is_eof   = is_code(link.din, link.kin, K_EOF);
  assign k_any    = |link.kin;
  assign kerr     = k_any && (state_q inside {S_HDR, S_PAY, S_TRL});
  assign hdr_last = (wcnt_q == WC_W'(N_HDR - 1));
  assign pay_last = (wcnt_q == WC_W'(PAYLOAD_WORDS - 1));

  // State register
  always_ff @(posedge fclk) begin
    if (reset_fclk) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state. A K-char inside a record aborts it; if that K-char is SOF the
  // abort and the start of the new header happen in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (is_sof) state_d = S_HDR;
      S_HDR: begin
        if (k_any)         state_d = is_sof ? S_HDR : S_IDLE;
        else if (hdr_last) state_d = S_PAY;
      end
      S_PAY: begin
        if (k_any)         state_d = is_sof ? S_HDR : S_IDLE;
        else if (pay_last) state_d = S_TRL;
      end
      S_TRL: begin
        if (k_any) state_d = is_sof ? S_HDR : S_IDLE;
        else       state_d = S_EOF;
      end
      S_EOF:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath decode (registered below)
  always_comb begin
    m_valid_d = 1'b0;
    m_last_d  = 1'b0;
    hdr_load  = 1'b0;
    done_d    = 1'b0;
    good_d    = 1'b0;
    err_k_d   = 1'b0;
    err_c_d   = 1'b0;
    err_e_d   = 1'b0;
    csum_clr  = 1'b0;
    csum_acc  = 1'b0;
    if (kerr) begin
      done_d   = 1'b1;
      err_k_d  = 1'b1;
      csum_clr = is_sof;
    end
    case (state_q)
      S_IDLE: csum_clr = is_sof;
      S_HDR: begin
        csum_acc = !k_any;
        hdr_load = !k_any && hdr_last;
      end
      S_PAY: begin
        csum_acc  = !k_any;
        m_valid_d = !k_any;
        m_last_d  = !k_any && pay_last;
      end
      S_EOF: begin
        done_d  = 1'b1;
        err_c_d = csum_bad_q;
        err_e_d = !is_eof;
        good_d  = !csum_bad_q && is_eof;
      end
      default: ;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (reset_fclk) begin
      wcnt_q        <= '0;
      csum_q        <= '0;
      csum_bad_q    <= 1'b0;
      h0_q          <= '0;
      h1_q          <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      hdr_version   <= '0;
      hdr_detector  <= '0;
      hdr_crate     <= '0;
      hdr_slot      <= '0;
      hdr_channel   <= '0;
      hdr_timestamp <= '0;
      hdr_valid     <= 1'b0;
      frame_done    <= 1'b0;
      frame_good    <= 1'b0;
      err_kchar     <= 1'b0;
      err_checksum  <= 1'b0;
      err_eof       <= 1'b0;
    end else begin
      // Word counter restarts on every state change and on an abort-restart.
      if (state_q == S_IDLE || state_d != state_q || kerr) wcnt_q <= '0;
      else                                                wcnt_q <= wcnt_q + WC_W'(1);

      if (csum_clr)      csum_q <= '0;
      else if (csum_acc) csum_q <= csum_q ^ link.din;

      if (state_q == S_TRL && !k_any) csum_bad_q <= (link.din != csum_q);

      if (state_q == S_HDR && !k_any) begin
        if (wcnt_q == WC_W'(0)) h0_q <= link.din;
        if (wcnt_q == WC_W'(1)) h1_q <= link.din;
      end

      if (hdr_load) begin
        hdr_version   <= h0_q[31:26];
        hdr_detector  <= h0_q[25:20];
        hdr_crate     <= h0_q[19:10];
        hdr_slot      <= h0_q[9:6];
        hdr_channel   <= h0_q[5:0];
        hdr_timestamp <= {link.din, h1_q};
      end

      if (m_valid_d) m_data_q <= link.din;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      hdr_valid    <= hdr_load;
      frame_done   <= done_d;
      frame_good   <= good_d;
      err_kchar    <= err_k_d;
      err_checksum <= err_c_d;
      err_eof      <= err_e_d;
    end
  end

  assign link.m_data  = m_data_q;
  assign link.m_valid = m_valid_q;
  assign link.m_last  = m_last_q;

  // Counters step on the same edge that raises frame_done.
  st40_rx_counter #(.CNT_W(CNT_W), .WRAP(1'b1)) u_ok_cnt (
    .clk   (fclk),
    .rst   (reset_fclk),
    .inc   (done_d && good_d),
    .clr   (clear_counters),
    .count (ok_count)
  );

  st40_rx_counter #(.CNT_W(CNT_W), .WRAP(1'b1)) u_err_cnt (
    .clk   (fclk),
    .rst   (reset_fclk),
    .inc   (done_d && !good_d),
    .clr   (clear_counters),
    .count (err_count)
  );

endmodule

// File: tb/tb_st40_frame_receiver.sv
// Directed-sequence bench for st40_frame_receiver with random payloads.
// Frames are built from the record format; expectations come from how each
// frame was constructed (header field slices, XOR of the words sent, which
// record slot was corrupted).
module tb_st40_frame_receiver;
  import st40_link_pkg::*;

  localparam int unsigned PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  st40_frame_receiver_if link_if ();

  logic [5:0]  hdr_version, hdr_detector, hdr_channel;
  logic [9:0]  hdr_crate;
  logic [3:0]  hdr_slot;
  logic [63:0] hdr_timestamp;
  logic        hdr_valid, frame_done, frame_good, err_kchar, err_checksum, err_eof;
  logic [31:0] ok_count, err_count;

  st40_frame_receiver #(.PAYLOAD_WORDS(PW), .CNT_W(32)) dut (
    .fclk          (clk),
    .reset_fclk    (rst),
    .link          (link_if),
    .clear_counters(clr),
    .hdr_version   (hdr_version),
    .hdr_detector  (hdr_detector),
    .hdr_crate     (hdr_crate),
    .hdr_slot      (hdr_slot),
    .hdr_channel   (hdr_channel),
    .hdr_timestamp (hdr_timestamp),
    .hdr_valid     (hdr_valid),
    .frame_done    (frame_done),
    .frame_good    (frame_good),
    .err_kchar     (err_kchar),
    .err_checksum  (err_checksum),
    .err_eof       (err_eof),
    .ok_count      (ok_count),
    .err_count     (err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observations collected on the falling edge
  logic [31:0] pay_q[$];
  logic        last_q[$];
  logic [3:0]  done_q[$];   // {good, kchar, checksum, eof}
  int          hdr_cnt = 0;
  int          stray   = 0;

  initial forever begin
    @(negedge clk);
    if (link_if.m_valid) begin
      pay_q.push_back(link_if.m_data);
      last_q.push_back(link_if.m_last);
    end else if (link_if.m_last) begin
      stray++;
    end
    if (hdr_valid) hdr_cnt++;
    if (frame_done) done_q.push_back({frame_good, err_kchar, err_checksum, err_eof});
    else if (frame_good || err_kchar || err_checksum || err_eof) stray++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input bit c = 1'b0);
    @(negedge clk);
    link_if.din = d;
    link_if.kin = k;
    clr         = c;
  endtask

  task automatic send_idle(input int n);
    repeat (n) drive(K_IDLE, KFLAG_CTRL);
  endtask

  task automatic rand_pay(output logic [31:0] p[$]);
    p = {};
    repeat (PW) p.push_back($urandom());
  endtask

  task automatic send_hdr(input logic [31:0] h0, input logic [63:0] ts);
    drive(K_SOF, KFLAG_CTRL);
    drive(h0, 4'b0);
    drive(ts[31:0], 4'b0);
    drive(ts[63:32], 4'b0);
  endtask

  task automatic send_frame(input logic [31:0] h0, input logic [63:0] ts, input logic [31:0] p[$],
                            input bit flip, input bit bad_eof, input bit clr_eof);
    logic [31:0] x;
    x = h0 ^ ts[31:0] ^ ts[63:32];
    foreach (p[i]) x ^= p[i];
    send_hdr(h0, ts);
    foreach (p[i]) drive(p[i], 4'b0);
    drive(x ^ {31'b0, flip}, 4'b0);
    if (bad_eof) drive(K_EOF, 4'b0, clr_eof);   // EOF value but sent as data
    else         drive(K_EOF, KFLAG_CTRL, clr_eof);
  endtask

  // Let the last outputs land, then look between edges.
  task automatic settle();
    send_idle(3);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    pay_q = {};
    last_q = {};
    done_q = {};
    hdr_cnt = 0;
  endtask

  task automatic check_hdr(input string tag, input logic [31:0] h0, input logic [63:0] ts);
    check({tag, "_ver"},  64'(hdr_version),  64'(h0[31:26]));
    check({tag, "_det"},  64'(hdr_detector), 64'(h0[25:20]));
    check({tag, "_crate"},64'(hdr_crate),    64'(h0[19:10]));
    check({tag, "_slot"}, 64'(hdr_slot),     64'(h0[9:6]));
    check({tag, "_chan"}, 64'(hdr_channel),  64'(h0[5:0]));
    check({tag, "_ts"},   hdr_timestamp,     ts);
  endtask

  // exp: expected stream words; last_idx: index carrying m_last (-1 = none)
  task automatic check_pay(input string tag, input logic [31:0] exp[$], input int last_idx);
    check({tag, "_npay"}, 64'(pay_q.size()), 64'(exp.size()));
    foreach (exp[i]) begin
      if (i < pay_q.size()) begin
        check($sformatf("%s_pay%0d", tag, i), 64'(pay_q[i]), 64'(exp[i]));
        check($sformatf("%s_last%0d", tag, i), 64'(last_q[i]), 64'(i == last_idx));
      end
    end
  endtask

  task automatic check_done(input string tag, input int idx, input logic [3:0] exp);
    if (idx < done_q.size()) check($sformatf("%s_done%0d", tag, idx), 64'(done_q[idx]), 64'(exp));
    else                     check($sformatf("%s_done%0d_missing", tag, idx), 64'(done_q.size()), 64'(idx + 1));
  endtask

  logic [31:0] p1[$], p2[$], exp_pay[$];
  logic [31:0] h0a, h0b;
  logic [63:0] tsa, tsb;

  initial begin
    link_if.din = K_IDLE;
    link_if.kin = KFLAG_CTRL;
    repeat (3) @(negedge clk);
    check("rst_ok",    64'(ok_count), 64'(0));
    check("rst_err",   64'(err_count), 64'(0));
    check("rst_valid", 64'(link_if.m_valid), 64'(0));
    check("rst_done",  64'(frame_done), 64'(0));
    check("rst_ts",    hdr_timestamp, 64'(0));
    rst = 1'b0;
    send_idle(5);
    settle();
    check("idle_npay", 64'(pay_q.size()), 64'(0));
    check("idle_ndone", 64'(done_q.size()), 64'(0));
    clear_obs();

    // 1: clean frame
    rand_pay(p1);
    send_frame(32'h1234_5678, 64'h1_0000_0002, p1, 1'b0, 1'b0, 1'b0);
    settle();
    check("t1_slot", 64'(hdr_slot), 64'h9);
    check_hdr("t1", 32'h1234_5678, 64'h1_0000_0002);
    check("t1_nhdr", 64'(hdr_cnt), 64'(1));
    check_pay("t1", p1, PW - 1);
    check("t1_ndone", 64'(done_q.size()), 64'(1));
    check_done("t1", 0, 4'b1000);
    check("t1_ok", 64'(ok_count), 64'(1));
    check("t1_err", 64'(err_count), 64'(0));
    clear_obs();

    // 2: trailer bit0 flipped
    rand_pay(p1);
    send_frame(32'h1234_5678, 64'h1_0000_0002, p1, 1'b1, 1'b0, 1'b0);
    settle();
    check_pay("t2", p1, PW - 1);
    check("t2_ndone", 64'(done_q.size()), 64'(1));
    check_done("t2", 0, 4'b0010);
    check("t2_ok", 64'(ok_count), 64'(1));
    check("t2_err", 64'(err_count), 64'(1));
    clear_obs();

    // 3: K-char as second payload word, then a clean frame
    h0a = $urandom(); tsa = {$urandom(), $urandom()};
    rand_pay(p1);
    send_hdr(h0a, tsa);
    drive(p1[0], 4'b0);
    drive(K_IDLE, KFLAG_CTRL);
    settle();
    exp_pay = {p1[0]};
    check_pay("t3", exp_pay, -1);
    check("t3_ndone", 64'(done_q.size()), 64'(1));
    check_done("t3", 0, 4'b0100);
    check("t3_err", 64'(err_count), 64'(2));
    clear_obs();
    rand_pay(p2);
    send_frame(h0a, tsa, p2, 1'b0, 1'b0, 1'b0);
    settle();
    check_done("t3b", 0, 4'b1000);
    check_pay("t3b", p2, PW - 1);
    check("t3b_ok", 64'(ok_count), 64'(2));
    clear_obs();

    // 4: SOF mid-payload restarts into a clean frame
    h0a = $urandom(); tsa = {$urandom(), $urandom()};
    h0b = $urandom(); tsb = {$urandom(), $urandom()};
    rand_pay(p1);
    rand_pay(p2);
    send_hdr(h0a, tsa);
    drive(p1[0], 4'b0);
    drive(p1[1], 4'b0);
    send_frame(h0b, tsb, p2, 1'b0, 1'b0, 1'b0);
    settle();
    exp_pay = {p1[0], p1[1]};
    foreach (p2[i]) exp_pay.push_back(p2[i]);
    check_pay("t4", exp_pay, 2 + PW - 1);
    check("t4_ndone", 64'(done_q.size()), 64'(2));
    check_done("t4", 0, 4'b0100);
    check_done("t4", 1, 4'b1000);
    check("t4_nhdr", 64'(hdr_cnt), 64'(2));
    check_hdr("t4", h0b, tsb);
    check("t4_ok", 64'(ok_count), 64'(3));
    check("t4_err", 64'(err_count), 64'(3));
    clear_obs();

    // 5: data word in the EOF slot, then a normal frame
    rand_pay(p1);
    send_frame($urandom(), {$urandom(), $urandom()}, p1, 1'b0, 1'b1, 1'b0);
    rand_pay(p2);
    send_frame(h0b, tsb, p2, 1'b0, 1'b0, 1'b0);
    settle();
    check("t5_ndone", 64'(done_q.size()), 64'(2));
    check_done("t5", 0, 4'b0001);
    check_done("t5", 1, 4'b1000);
    check("t5_ok", 64'(ok_count), 64'(4));
    check("t5_err", 64'(err_count), 64'(4));
    clear_obs();

    // 6: reset mid-payload, then clear_counters alongside a good frame end
    rand_pay(p1);
    send_hdr(h0a, tsa);
    drive(p1[0], 4'b0);
    drive(p1[1], 4'b0);
    @(negedge clk);
    link_if.din = p1[2];
    link_if.kin = 4'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_ok", 64'(ok_count), 64'(0));
    check("t6_rst_err", 64'(err_count), 64'(0));
    check("t6_rst_valid", 64'(link_if.m_valid), 64'(0));
    check("t6_rst_data", 64'(link_if.m_data), 64'(0));
    check("t6_rst_ts", hdr_timestamp, 64'(0));
    check("t6_rst_done", 64'(frame_done), 64'(0));
    clear_obs();
    @(negedge clk);
    rst = 1'b0;
    link_if.din = p1[3];
    drive(32'h5A5A_0F0F, 4'b0);
    drive(K_EOF, KFLAG_CTRL);
    settle();
    check("t6_ndone", 64'(done_q.size()), 64'(0));
    check("t6_npay", 64'(pay_q.size()), 64'(0));
    clear_obs();
    send_frame(h0b, tsb, p1, 1'b0, 1'b0, 1'b1);
    settle();
    check_done("t6c", 0, 4'b1000);
    check("t6c_ok", 64'(ok_count), 64'(0));
    check("t6c_err", 64'(err_count), 64'(0));
    clear_obs();
    send_frame(h0a, tsa, p2, 1'b0, 1'b0, 1'b0);
    settle();
    check("t6d_ok", 64'(ok_count), 64'(1));
    check_hdr("t6d", h0a, tsa);

    check("stray_pulses", 64'(stray), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
